// File: rtl/conv_sequencer.sv
// Convolution sequencer: loads image columns into memory, then streams
// them to the convolution unit and schedules result-memory writes.
module conv_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int CONV_LAT = 2
) (
  input  logic              i_CLK,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_run,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_imgLength,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_conv_valid,
  output logic              o_out_we,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_EOP,
  output logic              o_overflow,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DW = $clog2(CONV_LAT + 1) + 1;

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] len;
  logic [DW-1:0]     dcnt;
  logic              run_last;
  logic              enter_load;
  logic              enter_run;
  logic              enter_drain;

  // The first two columns only prime the window, hence the k>=2 gate.
  logic [CONV_LAT:0] we_pipe;
  logic [ADDR_W-1:0] oa_pipe [CONV_LAT+1];

  assign run_last    = (len == '0) || (cnt == len - ADDR_W'(1));
  assign enter_load  = (state == IDLE) && (nxt == LOAD);
  assign enter_run   = (state != RUN) && (nxt == RUN);
  assign enter_drain = (state != DRAIN) && (nxt == DRAIN);

  assign o_state    = state;
  assign o_out_we   = we_pipe[CONV_LAT];
  assign o_out_addr = oa_pipe[CONV_LAT];

  // State register.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  // Next-state decode; run wins over load from IDLE.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (i_run)       nxt = RUN;
        else if (i_load) nxt = LOAD;
      end
      LOAD: begin
        if (i_run)        nxt = RUN;
        else if (!i_load) nxt = IDLE;
      end
      RUN: begin
        if (run_last) nxt = DRAIN;
      end
      DRAIN: begin
        if (dcnt == DW'(CONV_LAT)) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Counters, memory strobes and the result-write delay line.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt          <= '0;
      len          <= '0;
      dcnt         <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_conv_valid <= 1'b0;
      o_EOP        <= 1'b0;
      o_overflow   <= 1'b0;
      we_pipe      <= '0;
      for (int i = 0; i <= CONV_LAT; i++) oa_pipe[i] <= '0;
    end else begin
      o_wr_en      <= 1'b0;
      o_rd_en      <= 1'b0;
      o_EOP        <= (nxt == DONE);
      o_conv_valid <= o_rd_en;
      we_pipe[0]   <= o_rd_en && (o_rd_addr >= ADDR_W'(2));
      oa_pipe[0]   <= o_rd_addr - ADDR_W'(2);
      for (int i = 1; i <= CONV_LAT; i++) begin
        we_pipe[i] <= we_pipe[i-1];
        oa_pipe[i] <= oa_pipe[i-1];
      end
      unique case (state)
        LOAD: begin
          if (i_valid) begin
            if (cnt < len) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= cnt;
              cnt       <= cnt + ADDR_W'(1);
            end else begin
              o_overflow <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt < len) begin
            o_rd_en   <= 1'b1;
            o_rd_addr <= cnt;
            cnt       <= cnt + ADDR_W'(1);
          end
        end
        DRAIN:   dcnt <= dcnt + DW'(1);
        default: ;
      endcase
      if (enter_load) begin
        len        <= i_imgLength;
        cnt        <= '0;
        o_overflow <= 1'b0;
      end
      if (enter_run) begin
        len <= i_imgLength;
        cnt <= '0;
      end
      if (enter_drain) dcnt <= '0;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed vector bench for conv_sequencer.
// Each row: inputs held for one cycle, outputs expected after the edge.
module tb_conv_sequencer;

  localparam int AW = 10;

  logic          i_CLK = 1'b0;
  logic          i_rst_n;
  logic          i_load;
  logic          i_run;
  logic          i_valid;
  logic [AW-1:0] i_imgLength;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic          o_conv_valid;
  logic          o_out_we;
  logic [AW-1:0] o_out_addr;
  logic          o_EOP;
  logic          o_overflow;
  logic [2:0]    o_state;

  conv_sequencer #(.ADDR_W(AW), .CONV_LAT(2)) dut (
    .i_CLK(i_CLK), .i_rst_n(i_rst_n), .i_load(i_load), .i_run(i_run),
    .i_valid(i_valid), .i_imgLength(i_imgLength),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_conv_valid(o_conv_valid), .o_out_we(o_out_we),
    .o_out_addr(o_out_addr), .o_EOP(o_EOP),
    .o_overflow(o_overflow), .o_state(o_state)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    bit       ld, rn, vl;
    int       len;
    bit       wr;
    int       wa;
    bit       rd;
    int       ra;
    bit       cv, we;
    int       oa;
    bit       eop, ovf;
    int       st;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ld rn vl len | wr wa rd ra cv we oa eop ovf st  (addr -1 = don't care)
  function automatic vec_t v(bit ld, bit rn, bit vl, int len,
                             bit wr, int wa, bit rd, int ra,
                             bit cv, bit we, int oa,
                             bit eop, bit ovf, int st);
    vec_t r;
    r.ld = ld; r.rn = rn; r.vl = vl; r.len = len;
    r.wr = wr; r.wa = wa; r.rd = rd; r.ra = ra;
    r.cv = cv; r.we = we; r.oa = oa;
    r.eop = eop; r.ovf = ovf; r.st = st;
    return r;
  endfunction

  task automatic drive(input bit ld, input bit rn, input bit vl, input int len);
    i_load = ld; i_run = rn; i_valid = vl; i_imgLength = AW'(len);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0);
    @(posedge i_CLK); #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " wr_en"}, int'(o_wr_en), 0);
    chk({tag, " wr_addr"}, int'(o_wr_addr), 0);
    chk({tag, " rd_en"}, int'(o_rd_en), 0);
    chk({tag, " rd_addr"}, int'(o_rd_addr), 0);
    chk({tag, " conv_valid"}, int'(o_conv_valid), 0);
    chk({tag, " out_we"}, int'(o_out_we), 0);
    chk({tag, " out_addr"}, int'(o_out_addr), 0);
    chk({tag, " eop"}, int'(o_EOP), 0);
    chk({tag, " ovf"}, int'(o_overflow), 0);
    chk({tag, " state"}, int'(o_state), 0);
  endtask

  initial begin
    // Load len 5: five writes then an overrun pulse.
    vecs.push_back(v(1,0,0,5, 0,-1,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,0,1,5, 1, 0,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,0,1,5, 1, 1,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,0,1,5, 1, 2,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,0,1,5, 1, 3,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,0,1,5, 1, 4,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,0,1,5, 0,-1,0,-1, 0,0,-1, 0,1,1));
    vecs.push_back(v(0,0,0,5, 0,-1,0,-1, 0,0,-1, 0,1,0));
    // Run len 5; run drops mid-sequence without aborting.
    vecs.push_back(v(0,1,0,5, 0,-1,0,-1, 0,0,-1, 0,1,2));
    vecs.push_back(v(0,1,0,5, 0,-1,1, 0, 0,0,-1, 0,1,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 1, 1,0,-1, 0,1,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 2, 1,0,-1, 0,1,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 3, 1,0,-1, 0,1,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 4, 1,0,-1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 1,1, 0, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,1, 1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,1, 2, 1,1,4));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,1,0));
    // Run len 0: no reads, three drain cycles, EOP.
    vecs.push_back(v(0,1,0,0, 0,-1,0,-1, 0,0,-1, 0,1,2));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 1,1,4));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,1,0));
    // Run len 2: two reads, no result writes.
    vecs.push_back(v(0,1,0,2, 0,-1,0,-1, 0,0,-1, 0,1,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 0, 0,0,-1, 0,1,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 1, 1,0,-1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 1,0,-1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,1,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 1,1,4));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,1,0));
    // Load then run+valid together; len re-sampled to 3 on run entry.
    vecs.push_back(v(1,0,0,4, 0,-1,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,0,1,4, 1, 0,0,-1, 0,0,-1, 0,0,1));
    vecs.push_back(v(1,1,1,3, 1, 1,0,-1, 0,0,-1, 0,0,2));
    vecs.push_back(v(1,0,1,0, 0,-1,1, 0, 0,0,-1, 0,0,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 1, 1,0,-1, 0,0,2));
    vecs.push_back(v(0,0,0,0, 0,-1,1, 2, 1,0,-1, 0,0,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 1,0,-1, 0,0,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,0,3));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,1, 0, 1,0,4));
    vecs.push_back(v(0,0,0,0, 0,-1,0,-1, 0,0,-1, 0,0,0));

    i_rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge i_CLK);
    #1;
    all_zero("reset");
    @(negedge i_CLK);
    i_rst_n = 1'b1;
    @(posedge i_CLK); #1;

    foreach (vecs[i]) begin
      vec_t r;
      string t;
      r = vecs[i];
      t = $sformatf("row%0d", i);
      drive(r.ld, r.rn, r.vl, r.len);
      @(posedge i_CLK); #1;
      chk({t, " wr_en"}, int'(o_wr_en), int'(r.wr));
      if (r.wr) chk({t, " wr_addr"}, int'(o_wr_addr), r.wa);
      chk({t, " rd_en"}, int'(o_rd_en), int'(r.rd));
      if (r.rd) chk({t, " rd_addr"}, int'(o_rd_addr), r.ra);
      chk({t, " conv_valid"}, int'(o_conv_valid), int'(r.cv));
      chk({t, " out_we"}, int'(o_out_we), int'(r.we));
      if (r.we) chk({t, " out_addr"}, int'(o_out_addr), r.oa);
      chk({t, " eop"}, int'(o_EOP), int'(r.eop));
      chk({t, " ovf"}, int'(o_overflow), int'(r.ovf));
      chk({t, " state"}, int'(o_state), r.st);
    end

    // Reset at read 3 of 8 clears everything asynchronously.
    begin
      bit hit;
      hit = 1'b0;
      drive(0, 1, 0, 8);
      @(posedge i_CLK); #1;
      for (int c = 0; c < 20 && !hit; c++) begin
        drive(0, 1, 0, 8);
        @(posedge i_CLK); #1;
        if (o_rd_en && o_rd_addr == AW'(3)) hit = 1'b1;
      end
      chk("reach read3", int'(hit), 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      all_zero("async rst");
      drive(0, 0, 0, 0);
      @(posedge i_CLK); #1;
      @(negedge i_CLK);
      i_rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        idle_cycle();
        chk("post-rst quiet",
            int'({o_wr_en, o_rd_en, o_conv_valid, o_out_we, o_EOP}), 0);
        chk("post-rst state", int'(o_state), 0);
      end
    end

    // Re-run after reset, len 1: one read, no result write, EOP.
    begin
      int rds, wes, eops;
      rds = 0; wes = 0; eops = 0;
      drive(0, 1, 0, 1);
      @(posedge i_CLK); #1;
      drive(0, 0, 0, 0);
      for (int c = 0; c < 10; c++) begin
        @(posedge i_CLK); #1;
        rds  += int'(o_rd_en);
        wes  += int'(o_out_we);
        eops += int'(o_EOP);
      end
      chk("len1 reads", rds, 1);
      chk("len1 out_we", wes, 0);
      chk("len1 eop", eops, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
